// File: rtl/lsu_apb_bridge.sv
// Load/store unit to APB bridge: sizes, strobes, alignment checks and load extension.
// Optional macro LSU_APB_TIMEOUT_EN aborts an ACCESS phase after TIMEOUT_CYCLES wait states.
module lsu_apb_bridge #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        we,
  input  logic [2:0]  funct3,
  input  logic [31:0] dAddr,
  input  logic [31:0] dWdata,
  output logic [31:0] dRdata,
  output logic        stall,
  output logic        misalign,
  output logic        bus_err,
  output logic [31:0] PADDR,
  output logic        PSEL,
  output logic        PENABLE,
  output logic        PWRITE,
  output logic [31:0] PWDATA,
  output logic [3:0]  PSTRB,
  input  logic [31:0] PRDATA,
  input  logic        PREADY,
  input  logic        PSLVERR
);
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_t;

  state_t      state;
  logic        stall_r;
  logic [1:0]  sz_r;
  logic        uns_r;
  logic [1:0]  off_r;
  logic        bad;
  logic [3:0]  strb_n;
  logic [31:0] wdata_n;
  logic [31:0] lane;
  logic [31:0] ld;
  logic        tmo;

  always_comb begin
    bad = 1'b0;
    case (funct3[1:0])
      2'b01:   bad = dAddr[0];
      2'b10:   bad = (dAddr[1:0] != 2'b00);
      2'b11:   bad = 1'b1;
      default: bad = 1'b0;
    endcase
    if (funct3 == 3'b110) bad = 1'b1;
    if (we && funct3[2])  bad = 1'b1;
  end

  // Replicate store data across lanes so the strobe alone picks the bytes.
  always_comb begin
    strb_n  = 4'b1111;
    wdata_n = dWdata;
    case (funct3[1:0])
      2'b00: begin
        strb_n  = 4'b0001 << dAddr[1:0];
        wdata_n = {4{dWdata[7:0]}};
      end
      2'b01: begin
        strb_n  = dAddr[1] ? 4'b1100 : 4'b0011;
        wdata_n = {2{dWdata[15:0]}};
      end
      default: ;
    endcase
    if (!we) strb_n = 4'b0000;
  end

  assign lane = PRDATA >> {off_r, 3'b000};

  always_comb begin
    case (sz_r)
      2'b00:   ld = uns_r ? {24'b0, lane[7:0]}  : {{24{lane[7]}}, lane[7:0]};
      2'b01:   ld = uns_r ? {16'b0, lane[15:0]} : {{16{lane[15]}}, lane[15:0]};
      default: ld = PRDATA;
    endcase
  end

`ifdef LSU_APB_TIMEOUT_EN
  localparam logic [31:0] TO_LAST = TIMEOUT_CYCLES - 1;
  logic [31:0] tcnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                          tcnt <= '0;
    else if (state == SETUP)           tcnt <= '0;
    else if (state == ACCESS && !PREADY) tcnt <= tcnt + 32'd1;
  end

  assign tmo = !PREADY && (tcnt == TO_LAST);
`else
  assign tmo = 1'b0;
`endif

  // Gated by reset so every output reads 0 while reset is held.
  assign stall = rst & ((state == IDLE) ? req : stall_r);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      stall_r  <= 1'b0;
      dRdata   <= '0;
      misalign <= 1'b0;
      bus_err  <= 1'b0;
      PADDR    <= '0;
      PSEL     <= 1'b0;
      PENABLE  <= 1'b0;
      PWRITE   <= 1'b0;
      PWDATA   <= '0;
      PSTRB    <= '0;
      sz_r     <= '0;
      uns_r    <= 1'b0;
      off_r    <= '0;
    end else begin
      misalign <= 1'b0;
      bus_err  <= 1'b0;
      case (state)
        IDLE: if (req) begin
          if (bad) begin
            state    <= DONE;
            misalign <= 1'b1;
            stall_r  <= 1'b0;
            if (!we) dRdata <= '0;
          end else begin
            state   <= SETUP;
            stall_r <= 1'b1;
            PSEL    <= 1'b1;
            PADDR   <= {dAddr[31:2], 2'b00};
            PWRITE  <= we;
            PSTRB   <= strb_n;
            PWDATA  <= wdata_n;
            sz_r    <= funct3[1:0];
            uns_r   <= funct3[2];
            off_r   <= dAddr[1:0];
          end
        end
        SETUP: begin
          PENABLE <= 1'b1;
          state   <= ACCESS;
        end
        ACCESS: if (PREADY || tmo) begin
          state   <= DONE;
          PSEL    <= 1'b0;
          PENABLE <= 1'b0;
          stall_r <= 1'b0;
          if (!PREADY || PSLVERR) begin
            bus_err <= 1'b1;
            if (!PWRITE) dRdata <= '0;
          end else if (!PWRITE) begin
            dRdata <= ld;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_lsu_apb_bridge.sv
// Directed bench for lsu_apb_bridge: driver pushes expectations, monitor checks at each DONE cycle.
module tb_lsu_apb_bridge;
  logic        clk = 1'b0;
  logic        rst;
  logic        req, we;
  logic [2:0]  funct3;
  logic [31:0] dAddr, dWdata, dRdata;
  logic        stall, misalign, bus_err;
  logic [31:0] PADDR, PWDATA, PRDATA;
  logic        PSEL, PENABLE, PWRITE, PREADY, PSLVERR;
  logic [3:0]  PSTRB;

  lsu_apb_bridge dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .funct3(funct3), .dAddr(dAddr),
    .dWdata(dWdata), .dRdata(dRdata), .stall(stall), .misalign(misalign),
    .bus_err(bus_err), .PADDR(PADDR), .PSEL(PSEL), .PENABLE(PENABLE),
    .PWRITE(PWRITE), .PWDATA(PWDATA), .PSTRB(PSTRB), .PRDATA(PRDATA),
    .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rd;
    logic        mis;
    logic        berr;
    int          scyc;
    logic        psel;
    logic [31:0] paddr;
    logic [3:0]  strb;
    logic [31:0] pwd;
    logic        pw;
  } exp_t;

  exp_t q[$];
  int n_cmp = 0;
  int n_bad = 0;
  int done_cnt = 0;

  logic [31:0] sl_prd;
  int          sl_waits;
  logic        sl_err;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // APB slave: inserts sl_waits wait states, then returns sl_prd / sl_err.
  initial begin
    int wc;
    wc = 0;
    PREADY = 1'b0; PSLVERR = 1'b0; PRDATA = 32'h5A5A5A5A;
    forever begin
      @(negedge clk);
      if (PSEL && PENABLE) begin
        if (wc >= sl_waits) begin
          PREADY = 1'b1; PRDATA = sl_prd; PSLVERR = sl_err;
        end else begin
          PREADY = 1'b0; PRDATA = 32'h5A5A5A5A; PSLVERR = 1'b0;
        end
        wc++;
      end else begin
        PREADY = 1'b0; PSLVERR = 1'b0; PRDATA = 32'h5A5A5A5A; wc = 0;
      end
    end
  end

  // Monitor: DONE is the cycle where stall falls.
  initial begin
    int   scnt;
    logic prev, spur, saw, unstable;
    logic [68:0] cap;
    exp_t e;
    scnt = 0; prev = 0; spur = 0; saw = 0; unstable = 0; cap = '0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        scnt = 0; prev = 0; spur = 0; saw = 0; unstable = 0;
      end else begin
        if (PSEL && !PENABLE) begin
          saw = 1;
          cap = {PADDR, PSTRB, PWDATA, PWRITE};
        end else if (PSEL && PENABLE) begin
          if ({PADDR, PSTRB, PWDATA, PWRITE} != cap) unstable = 1;
        end
        if (prev && !stall) begin
          if (q.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL unexpected_done: got completion expected none");
          end else begin
            e = q.pop_front();
            cmp("dRdata", dRdata, e.rd);
            cmp("misalign", {31'b0, misalign}, {31'b0, e.mis});
            cmp("bus_err", {31'b0, bus_err}, {31'b0, e.berr});
            cmp("stall_cycles", scnt, e.scyc);
            cmp("psel_seen", {31'b0, saw}, {31'b0, e.psel});
            cmp("pulse_outside_done", {31'b0, spur}, 32'd0);
            if (e.psel) begin
              cmp("PADDR", cap[68:37], e.paddr);
              cmp("PSTRB", {28'b0, cap[36:33]}, {28'b0, e.strb});
              cmp("PWRITE", {31'b0, cap[0]}, {31'b0, e.pw});
              cmp("bus_stable", {31'b0, unstable}, 32'd0);
              if (e.pw) cmp("PWDATA", cap[32:1], e.pwd);
            end
          end
          done_cnt++;
          scnt = 0; spur = 0; saw = 0; unstable = 0;
        end else if (misalign || bus_err) begin
          spur = 1;
        end
        if (stall) scnt++;
        prev = stall;
      end
    end
  end

  task automatic op(input logic w, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                    input logic [31:0] prd, input int waits, input logic err,
                    input logic [31:0] e_rd, input logic e_mis, input logic e_berr, input int e_scyc,
                    input logic e_psel, input logic [31:0] e_paddr, input logic [3:0] e_strb,
                    input logic [31:0] e_pwd);
    exp_t e;
    int start, n;
    e.rd = e_rd; e.mis = e_mis; e.berr = e_berr; e.scyc = e_scyc; e.psel = e_psel;
    e.paddr = e_paddr; e.strb = e_strb; e.pwd = e_pwd; e.pw = w;
    q.push_back(e);
    start = done_cnt;
    @(posedge clk); #1;
    sl_prd = prd; sl_waits = waits; sl_err = err;
    req = 1'b1; we = w; funct3 = f3; dAddr = a; dWdata = wd;
    @(posedge clk); #1;
    // Dropping req and scrambling inputs after IDLE must not disturb the transfer.
    req = 1'b0; dAddr = 32'hFFFF_FFFF; dWdata = 32'h0; funct3 = 3'b011;
    n = 0;
    while (done_cnt == start && n < 60) begin
      @(posedge clk);
      n++;
    end
    if (done_cnt == start) begin
      n_cmp++; n_bad++;
      $display("FAIL completion_timeout: got no DONE expected DONE within 60 cycles");
      void'(q.pop_back());
    end
  endtask

  initial begin
    rst = 1'b0; req = 1'b0; we = 1'b0; funct3 = 3'b0; dAddr = '0; dWdata = '0;
    sl_prd = '0; sl_waits = 0; sl_err = 1'b0;
    repeat (2) @(posedge clk); #1;
    cmp("rst_dRdata", dRdata, 32'd0);
    cmp("rst_stall", {31'b0, stall}, 32'd0);
    cmp("rst_psel_pen", {30'b0, PSEL, PENABLE}, 32'd0);
    cmp("rst_paddr", PADDR, 32'd0);
    cmp("rst_pulses", {30'b0, misalign, bus_err}, 32'd0);
    cmp("rst_pwdata_strb", PWDATA | {28'b0, PSTRB} | {31'b0, PWRITE}, 32'd0);
    rst = 1'b1;

    //  w  f3      addr          wdata          prdata         wt err  rd             mis berr sc psel paddr          strb     pwdata
    op(0, 3'b010, 32'h100,      32'h0,         32'hDEADBEEF,  0, 0,   32'hDEADBEEF,  0,  0,  3, 1, 32'h100,      4'b0000, 32'h0);
    op(0, 3'b000, 32'h103,      32'h0,         32'h80123456,  0, 0,   32'hFFFFFF80,  0,  0,  3, 1, 32'h100,      4'b0000, 32'h0);
    op(0, 3'b100, 32'h103,      32'h0,         32'h80123456,  0, 0,   32'h00000080,  0,  0,  3, 1, 32'h100,      4'b0000, 32'h0);
    op(0, 3'b001, 32'h102,      32'h0,         32'h80123456,  0, 0,   32'hFFFF8012,  0,  0,  3, 1, 32'h100,      4'b0000, 32'h0);
    op(1, 3'b000, 32'h201,      32'h000000AB,  32'h0,         0, 0,   32'hFFFF8012,  0,  0,  3, 1, 32'h200,      4'b0010, 32'hABABABAB);
    op(1, 3'b001, 32'h202,      32'h1234CDEF,  32'h0,         0, 0,   32'hFFFF8012,  0,  0,  3, 1, 32'h200,      4'b1100, 32'hCDEFCDEF);
    op(1, 3'b010, 32'h300,      32'h11223344,  32'h0,         2, 0,   32'hFFFF8012,  0,  0,  5, 1, 32'h300,      4'b1111, 32'h11223344);
    op(0, 3'b010, 32'h102,      32'h0,         32'h0,         0, 0,   32'h00000000,  1,  0,  1, 0, 32'h0,        4'b0000, 32'h0);
    op(0, 3'b101, 32'h100,      32'h0,         32'h0000F00D,  1, 0,   32'h0000F00D,  0,  0,  4, 1, 32'h100,      4'b0000, 32'h0);
    op(0, 3'b001, 32'h100,      32'h0,         32'h0000F00D,  0, 0,   32'hFFFFF00D,  0,  0,  3, 1, 32'h100,      4'b0000, 32'h0);
    op(1, 3'b100, 32'h204,      32'h55,        32'h0,         0, 0,   32'hFFFFF00D,  1,  0,  1, 0, 32'h0,        4'b0000, 32'h0);
    op(0, 3'b110, 32'h000,      32'h0,         32'h0,         0, 0,   32'h00000000,  1,  0,  1, 0, 32'h0,        4'b0000, 32'h0);
    op(0, 3'b100, 32'h107,      32'h0,         32'hA5000000,  0, 0,   32'h000000A5,  0,  0,  3, 1, 32'h104,      4'b0000, 32'h0);
    op(0, 3'b011, 32'h100,      32'h0,         32'h0,         0, 0,   32'h00000000,  1,  0,  1, 0, 32'h0,        4'b0000, 32'h0);
    op(0, 3'b010, 32'h104,      32'h0,         32'h12345678,  5, 1,   32'h00000000,  0,  1,  8, 1, 32'h104,      4'b0000, 32'h0);
    op(0, 3'b010, 32'h108,      32'h0,         32'hCAFEF00D,  0, 0,   32'hCAFEF00D,  0,  0,  3, 1, 32'h108,      4'b0000, 32'h0);

    // Reset in the middle of a long ACCESS phase.
    @(posedge clk); #1;
    sl_prd = 32'h0; sl_waits = 40; sl_err = 1'b0;
    req = 1'b1; we = 1'b0; funct3 = 3'b010; dAddr = 32'h400;
    @(posedge clk); #1;
    req = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    cmp("mid_psel_pen_before_rst", {30'b0, PSEL, PENABLE}, 32'd3);
    rst = 1'b0;
    #1;
    cmp("mid_rst_psel_pen", {30'b0, PSEL, PENABLE}, 32'd0);
    cmp("mid_rst_stall", {31'b0, stall}, 32'd0);
    cmp("mid_rst_dRdata", dRdata, 32'd0);
    cmp("mid_rst_paddr", PADDR, 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    op(0, 3'b010, 32'h10C,      32'h0,         32'h13579BDF,  0, 0,   32'h13579BDF,  0,  0,  3, 1, 32'h10C,      4'b0000, 32'h0);

    repeat (3) @(posedge clk);
    cmp("queue_drained", q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
    $finish;
  end
endmodule
